// File: rtl/zacore_mem_responder.sv
// zacore_mem_responder
// Memory-side responder for the Zacore core memory interface. A word-organised
// RAM serves instruction fetches, data reads and byte-masked data writes. One
// read port is shared between fetch and data read. Data read always wins, and
// the fetch is told to retry through o_fetch_gnt. Every accepted read returns on
// a single registered bus one cycle later. The RAM is read-first, so a read
// sees the word as it was before a write in the same cycle.
//
// Ports
//   i_clk              clock, all state changes on the rising edge
//   i_rst              synchronous active-high reset
//   i_fetch_req        fetch request, held by the core until granted
//   i_fetch_addr       fetch byte address
//   o_fetch_gnt        combinational grant for the fetch in this cycle
//   i_read_req         data read request, always accepted
//   i_write_req        data write request, always accepted
//   i_data_addr        byte address for the data read/write
//   i_data_write       write data
//   i_data_write_mask  byte enables, bit n writes bits 8n+7:8n
//   o_data_read        registered read data, held when there is no response
//   o_rvalid           o_data_read carries a response this cycle
//   o_rsrc             response source, 0 = fetch, 1 = data read
//   o_fault            one-cycle pulse for an out-of-range response or a dropped write

module zacore_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetch_req,
    input  logic [31:0] i_fetch_addr,
    output logic        o_fetch_gnt,
    input  logic        i_read_req,
    input  logic        i_write_req,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_write,
    input  logic [3:0]  i_data_write_mask,
    output logic [31:0] o_data_read,
    output logic        o_rvalid,
    output logic        o_rsrc,
    output logic        o_fault
);

    logic [31:0] mem [DEPTH_WORDS];

    logic        read_acc;
    logic        fetch_acc;
    logic        resp_acc;
    logic [31:0] resp_addr;
    logic        resp_in_range;
    logic        write_in_range;
    logic        write_acc;
    logic        unused_byte_offset;

    // A byte address is in range when every bit above the word index is zero,
    // i.e. addr < DEPTH_WORDS*4 for a power-of-two depth.
    function automatic logic in_range(input logic [31:0] addr);
        return addr[31:ADDR_W+2] == '0;
    endfunction

    // Data read owns the read port. A fetch only gets it when no data read is
    // presented, and nothing is granted while reset is held.
    assign o_fetch_gnt    = !i_read_req && !i_rst;
    assign read_acc       = i_read_req && !i_rst;
    assign fetch_acc      = i_fetch_req && o_fetch_gnt;
    assign resp_acc       = read_acc || fetch_acc;
    assign resp_addr      = read_acc ? i_data_addr : i_fetch_addr;
    assign resp_in_range  = in_range(resp_addr);
    assign write_in_range = in_range(i_data_addr);
    assign write_acc      = i_write_req && !i_rst && write_in_range;

    // Byte offsets are deliberately ignored; accesses are always whole words.
    assign unused_byte_offset = ^resp_addr[1:0];

    // Backing RAM. It has no reset, and only the enabled bytes of an in-range
    // write are updated.
    always_ff @(posedge i_clk) begin
        if (write_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (i_data_write_mask[b]) begin
                    mem[i_data_addr[ADDR_W+1:2]][8*b +: 8] <= i_data_write[8*b +: 8];
                end
            end
        end
    end

    // Response stage. The RAM is read with non-blocking semantics, so a
    // same-cycle write is not yet visible (read-first). Out-of-range reads
    // return zero. A dropped write raises o_fault even though it has no
    // response of its own.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data_read <= '0;
            o_rvalid    <= 1'b0;
            o_rsrc      <= 1'b0;
            o_fault     <= 1'b0;
        end else begin
            o_rvalid <= resp_acc;
            o_rsrc   <= read_acc;
            o_fault  <= (resp_acc && !resp_in_range) || (i_write_req && !write_in_range);
            if (resp_acc) begin
                o_data_read <= resp_in_range ? mem[resp_addr[ADDR_W+1:2]] : '0;
            end
        end
    end

endmodule

// File: tb/tb_zacore_mem_responder.sv
// tb_zacore_mem_responder
// Testbench for zacore_mem_responder at DEPTH_WORDS = 1024. A behavioural model
// tracks the RAM as an array of words and predicts every response from the
// address arithmetic. A compare process checks the DUT against the model on
// each falling edge. Directed sequences pin the model with literal values, and
// a randomized phase follows.

module tb_zacore_mem_responder;

    localparam int          DEPTH = 1024;
    localparam int unsigned LIMIT = DEPTH * 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_fetch_req;
    logic [31:0] i_fetch_addr;
    logic        o_fetch_gnt;
    logic        i_read_req;
    logic        i_write_req;
    logic [31:0] i_data_addr;
    logic [31:0] i_data_write;
    logic [3:0]  i_data_write_mask;
    logic [31:0] o_data_read;
    logic        o_rvalid;
    logic        o_rsrc;
    logic        o_fault;

    int checks = 0;
    int errors = 0;

    zacore_mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_fetch_req       (i_fetch_req),
        .i_fetch_addr      (i_fetch_addr),
        .o_fetch_gnt       (o_fetch_gnt),
        .i_read_req        (i_read_req),
        .i_write_req       (i_write_req),
        .i_data_addr       (i_data_addr),
        .i_data_write      (i_data_write),
        .i_data_write_mask (i_data_write_mask),
        .o_data_read       (o_data_read),
        .o_rvalid          (o_rvalid),
        .o_rsrc            (o_rsrc),
        .o_fault           (o_fault)
    );

    always #5 i_clk = ~i_clk;

    // Compare one value against the expected value and log any difference.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive a full set of inputs shortly after the next rising edge.
    task automatic applyStimulus(input logic rst, input logic fr, input logic [31:0] fa,
                                 input logic rr, input logic wr, input logic [31:0] da,
                                 input logic [31:0] wd, input logic [3:0] m);
        @(posedge i_clk);
        #2;
        i_rst             = rst;
        i_fetch_req       = fr;
        i_fetch_addr      = fa;
        i_read_req        = rr;
        i_write_req       = wr;
        i_data_addr       = da;
        i_data_write      = wd;
        i_data_write_mask = m;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Behavioural model: the RAM is a word array indexed by byte address / 4.
    // Each cycle it works out what the next response must be and then applies
    // the write, which gives the read-first ordering.
    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_data   = '0;
    logic        exp_rvalid = 1'b0;
    logic        exp_rsrc   = 1'b0;
    logic        exp_fault  = 1'b0;
    logic        check_en   = 1'b0;
    logic        m_rd;
    logic        m_fe;
    int unsigned m_addr;

    always @(posedge i_clk) begin
        if (i_rst) begin
            exp_data   = '0;
            exp_rvalid = 1'b0;
            exp_rsrc   = 1'b0;
            exp_fault  = 1'b0;
        end else begin
            m_rd       = i_read_req;
            m_fe       = i_fetch_req && !i_read_req;
            m_addr     = m_rd ? i_data_addr : i_fetch_addr;
            exp_rvalid = m_rd || m_fe;
            exp_rsrc   = m_rd;
            exp_fault  = 1'b0;
            if (m_rd || m_fe) begin
                if (m_addr < LIMIT) begin
                    exp_data = model_mem[m_addr / 4];
                end else begin
                    exp_data  = '0;
                    exp_fault = 1'b1;
                end
            end
            if (i_write_req) begin
                if (i_data_addr < LIMIT) begin
                    for (int b = 0; b < 4; b++) begin
                        if (i_data_write_mask[b]) begin
                            model_mem[i_data_addr / 4][8*b +: 8] = i_data_write[8*b +: 8];
                        end
                    end
                end else begin
                    exp_fault = 1'b1;
                end
            end
        end
        check_en = 1'b1;
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge i_clk) begin
        if (check_en) begin
            checkOutput("rvalid", 32'(o_rvalid), 32'(exp_rvalid));
            checkOutput("rsrc", 32'(o_rsrc), 32'(exp_rsrc));
            checkOutput("fault", 32'(o_fault), 32'(exp_fault));
            checkOutput("data_read", o_data_read, exp_data);
            checkOutput("fetch_gnt", 32'(o_fetch_gnt), 32'(!i_read_req && !i_rst));
        end
    end

    // Random address: mostly one of the 32 preloaded words with any byte
    // offset, occasionally just past the end of the RAM.
    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) == 0) begin
            return LIMIT + $urandom_range(0, 65535);
        end
        return ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
    endfunction

    // Directed sequences with literal expectations, then randomized traffic.
    initial begin
        i_rst             = 1'b1;
        i_fetch_req       = 1'b0;
        i_fetch_addr      = 32'h0;
        i_read_req        = 1'b1;
        i_write_req       = 1'b0;
        i_data_addr       = 32'h10;
        i_data_write      = 32'h0;
        i_data_write_mask = 4'h0;

        // Reset held for two cycles with a data read pending.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge i_clk);
        checkOutput("reset_rvalid", 32'(o_rvalid), 32'h0);
        checkOutput("reset_data", o_data_read, 32'h0);
        idle();
        @(negedge i_clk);
        checkOutput("reset2_fault", 32'(o_fault), 32'h0);
        checkOutput("reset2_rvalid", 32'(o_rvalid), 32'h0);

        // Preload words 0..31. Words 0..3 get known values.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'(i * 4),
                          (i < 4) ? (32'hC0DE0000 | 32'(i)) : $urandom, 4'hF);
            if (i == 0) begin
                @(negedge i_clk);
                checkOutput("post_reset_rvalid", 32'(o_rvalid), 32'h0);
                checkOutput("post_reset_data", o_data_read, 32'h0);
            end
        end

        // Byte-masked write.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 32'h00000055, 4'b0001);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        idle();
        @(negedge i_clk);
        checkOutput("mask_data", o_data_read, 32'hDEADBE55);
        checkOutput("mask_rsrc", 32'(o_rsrc), 32'h1);

        // Read-first collision on the same word.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 32'h11111111, 4'hF);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h22222222, 4'hF);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        @(negedge i_clk);
        checkOutput("collide_old", o_data_read, 32'h11111111);
        idle();
        @(negedge i_clk);
        checkOutput("collide_new", o_data_read, 32'h22222222);

        // Arbitration: the data read blocks the fetch, then the fetch is granted.
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        #1 checkOutput("arb_gnt_low", 32'(o_fetch_gnt), 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1 checkOutput("arb_gnt_high", 32'(o_fetch_gnt), 32'h1);
        @(negedge i_clk);
        checkOutput("arb_data_rsrc", 32'(o_rsrc), 32'h1);
        checkOutput("arb_data", o_data_read, 32'hDEADBE55);
        idle();
        @(negedge i_clk);
        checkOutput("arb_fetch_rsrc", 32'(o_rsrc), 32'h0);
        checkOutput("arb_fetch_data", o_data_read, 32'hC0DE0000);

        // Streaming fetch over words 0..3.
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) applyStimulus(1'b0, 1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            else idle();
            @(negedge i_clk);
            checkOutput("stream_valid", 32'(o_rvalid), 32'h1);
            checkOutput("stream_data", o_data_read, 32'hC0DE0000 | 32'(i - 1));
        end

        // Out-of-range read, then an out-of-range write that must be dropped.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
        idle();
        @(negedge i_clk);
        checkOutput("oor_rd_valid", 32'(o_rvalid), 32'h1);
        checkOutput("oor_rd_data", o_data_read, 32'h0);
        checkOutput("oor_rd_fault", 32'(o_fault), 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
        @(negedge i_clk);
        checkOutput("oor_fault_clear", 32'(o_fault), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge i_clk);
        checkOutput("oor_wr_fault", 32'(o_fault), 32'h1);
        checkOutput("oor_wr_novalid", 32'(o_rvalid), 32'h0);
        idle();
        @(negedge i_clk);
        checkOutput("oor_word0", o_data_read, 32'hC0DE0000);

        // Randomized mixed traffic with occasional reset pulses.
        for (int n = 0; n < 2000; n++) begin
            applyStimulus($urandom_range(0, 63) == 0,
                          $urandom_range(0, 9) < 6, rand_addr(),
                          $urandom_range(0, 9) < 4,
                          $urandom_range(0, 9) < 4, rand_addr(),
                          $urandom, 4'($urandom_range(0, 15)));
        end
        idle();
        idle();
        @(negedge i_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
